// File: rtl/axi_rd_arb_if.sv
// AXI4 read-channel bundle. PORTS > 1 widens the AR fields and the per-port
// valid/ready bits for the requester side; the R payload is always shared.
interface axi_rd_arb_if #(
    parameter int PORTS      = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    logic [PORTS*ID_WIDTH-1:0]   arid;
    logic [PORTS*ADDR_WIDTH-1:0] araddr;
    logic [PORTS*8-1:0]          arlen;
    logic [PORTS*3-1:0]          arsize;
    logic [PORTS*2-1:0]          arburst;
    logic [PORTS-1:0]            arlock;
    logic [PORTS*4-1:0]          arcache;
    logic [PORTS*3-1:0]          arprot;
    logic [PORTS*4-1:0]          arqos;
    logic [PORTS-1:0]            arvalid;
    logic [PORTS-1:0]            arready;

    logic [ID_WIDTH-1:0]         rid;
    logic [DATA_WIDTH-1:0]       rdata;
    logic [1:0]                  rresp;
    logic                        rlast;
    logic [PORTS-1:0]            rvalid;
    logic [PORTS-1:0]            rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
        output arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
        input  arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arb.sv
// Round-robin AXI4 read arbiter: S_COUNT requesters share one registered AR master port,
// R beats are steered back by the port index carried in the upper ID bits.
module axi_rd_arb #(
    parameter int S_COUNT         = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    axi_rd_arb_if.slave  s_axi,
    axi_rd_arb_if.master m_axi
);
    localparam int SEL_W      = $clog2(S_COUNT);
    localparam int M_ID_WIDTH = ID_WIDTH + SEL_W;
    localparam int CNT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [SEL_W-1:0]      rr_ptr;
    logic [CNT_W-1:0]      cnt [S_COUNT];
    logic [S_COUNT-1:0]    eligible;
    logic                  slot_free;
    logic                  grant_valid;
    logic [SEL_W-1:0]      grant_idx;
    logic [SEL_W-1:0]      grant_next_ptr;

    logic [ID_WIDTH-1:0]   g_id;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [7:0]            g_len;
    logic [2:0]            g_size;
    logic [1:0]            g_burst;
    logic                  g_lock;
    logic [3:0]            g_cache;
    logic [2:0]            g_prot;
    logic [3:0]            g_qos;

    logic [SEL_W-1:0]      r_sel;
    logic                  r_sel_ok;
    logic                  r_done;

    always_comb begin
        for (int i = 0; i < S_COUNT; i++) begin
            eligible[i] = s_axi.arvalid[i] && (cnt[i] < CNT_MAX);
        end
    end

    // The output register can take a new AR when empty or when it drains this cycle.
    assign slot_free = !m_axi.arvalid || m_axi.arready;

    always_comb begin : arb_search
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < S_COUNT; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= S_COUNT) begin
                idx = idx - S_COUNT;
            end
            if (rst_n && slot_free && !grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = SEL_W'(idx);
            end
        end
    end

    assign grant_next_ptr = (grant_idx == SEL_W'(S_COUNT - 1)) ? '0 : grant_idx + SEL_W'(1);

    always_comb begin
        s_axi.arready = '0;
        g_id    = '0;
        g_addr  = '0;
        g_len   = '0;
        g_size  = '0;
        g_burst = '0;
        g_lock  = 1'b0;
        g_cache = '0;
        g_prot  = '0;
        g_qos   = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                s_axi.arready[i] = grant_valid;
                g_id    = s_axi.arid[i*ID_WIDTH +: ID_WIDTH];
                g_addr  = s_axi.araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                g_len   = s_axi.arlen[i*8 +: 8];
                g_size  = s_axi.arsize[i*3 +: 3];
                g_burst = s_axi.arburst[i*2 +: 2];
                g_lock  = s_axi.arlock[i];
                g_cache = s_axi.arcache[i*4 +: 4];
                g_prot  = s_axi.arprot[i*3 +: 3];
                g_qos   = s_axi.arqos[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axi.arvalid <= 1'b0;
            m_axi.arid    <= '0;
            m_axi.araddr  <= '0;
            m_axi.arlen   <= '0;
            m_axi.arsize  <= '0;
            m_axi.arburst <= '0;
            m_axi.arlock  <= '0;
            m_axi.arcache <= '0;
            m_axi.arprot  <= '0;
            m_axi.arqos   <= '0;
            rr_ptr        <= '0;
        end else if (grant_valid) begin
            m_axi.arvalid <= 1'b1;
            m_axi.arid    <= {grant_idx, g_id};
            m_axi.araddr  <= g_addr;
            m_axi.arlen   <= g_len;
            m_axi.arsize  <= g_size;
            m_axi.arburst <= g_burst;
            m_axi.arlock  <= g_lock;
            m_axi.arcache <= g_cache;
            m_axi.arprot  <= g_prot;
            m_axi.arqos   <= g_qos;
            rr_ptr        <= grant_next_ptr;
        end else if (m_axi.arready) begin
            m_axi.arvalid <= 1'b0;
        end
    end

    assign r_sel = m_axi.rid[M_ID_WIDTH-1 -: SEL_W];

    // Index codes beyond S_COUNT only exist when S_COUNT is not a power of two.
    if ((1 << SEL_W) == S_COUNT) begin : g_sel_full
        assign r_sel_ok = 1'b1;
    end else begin : g_sel_partial
        assign r_sel_ok = (int'(r_sel) < S_COUNT);
    end

    assign s_axi.rid   = m_axi.rid[ID_WIDTH-1:0];
    assign s_axi.rdata = m_axi.rdata;
    assign s_axi.rresp = m_axi.rresp;
    assign s_axi.rlast = m_axi.rlast;

    // Unroutable beats are swallowed so a stray ID can never stall the read channel.
    always_comb begin
        s_axi.rvalid = '0;
        m_axi.rready = 1'b1;
        for (int i = 0; i < S_COUNT; i++) begin
            if (r_sel_ok && (r_sel == SEL_W'(i))) begin
                s_axi.rvalid[i] = m_axi.rvalid;
                m_axi.rready    = s_axi.rready[i];
            end
        end
    end

    assign r_done = m_axi.rvalid && m_axi.rready && m_axi.rlast && r_sel_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < S_COUNT; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < S_COUNT; i++) begin
                if (grant_valid && (grant_idx == SEL_W'(i))) begin
                    if (!(r_done && (r_sel == SEL_W'(i)))) begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else if (r_done && (r_sel == SEL_W'(i)) && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_rd_arb.sv
// Self-checking bench for axi_rd_arb: a 2-port instance for arbitration, throttling and
// R routing, plus a 3-port instance for wrap-around and unroutable-ID handling.
module tb_axi_rd_arb;
    typedef struct {
        logic [8:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } r_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    ar_t  ar_exp[$];
    r_t   r_exp[$];

    axi_rd_arb_if #(.PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8))  s2 ();
    axi_rd_arb_if #(.PORTS(1), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(9))  m2 ();
    axi_rd_arb_if #(.PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8))  s3 ();
    axi_rd_arb_if #(.PORTS(1), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(10)) m3 ();

    axi_rd_arb #(.S_COUNT(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8), .MAX_OUTSTANDING(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .s_axi(s2), .m_axi(m2)
    );

    axi_rd_arb #(.S_COUNT(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8), .MAX_OUTSTANDING(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .s_axi(s3), .m_axi(m3)
    );

    always #5 clk = ~clk;

    // Master-side AR scoreboard: every accepted AR must match the oldest predicted grant.
    always @(negedge clk) begin
        ar_t e;
        if (rst_n && m2.arvalid[0] && m2.arready[0]) begin
            total_cnt++;
            if (ar_exp.size() == 0) begin
                $display("[TB] FAIL ar_scoreboard: got arid=%h with no grant expected", m2.arid);
            end else begin
                e = ar_exp.pop_front();
                if (m2.arid !== e.id || m2.araddr !== e.addr || m2.arlen !== e.len ||
                    m2.arsize !== 3'd2 || m2.arburst !== 2'b01) begin
                    $display("[TB] FAIL ar_scoreboard: got id=%h addr=%h len=%h size=%h burst=%h required id=%h addr=%h len=%h size=2 burst=1",
                             m2.arid, m2.araddr, m2.arlen, m2.arsize, m2.arburst, e.id, e.addr, e.len);
                end else begin
                    pass_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ar(input int p, input logic v, input logic [7:0] id,
                          input logic [31:0] addr, input logic [7:0] len);
        s2.arvalid[p]        = v;
        s2.arid[p*8 +: 8]    = id;
        s2.araddr[p*32 +: 32] = addr;
        s2.arlen[p*8 +: 8]   = len;
        s2.arsize[p*3 +: 3]  = 3'd2;
        s2.arburst[p*2 +: 2] = 2'b01;
    endtask

    task automatic push_ar(input int p, input logic [7:0] id, input logic [31:0] addr,
                           input logic [7:0] len);
        ar_t e;
        e.id   = {p[0], id};
        e.addr = addr;
        e.len  = len;
        ar_exp.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s2.arvalid = '0; s2.arid = '0; s2.araddr = '0; s2.arlen = '0; s2.arsize = '0;
        s2.arburst = '0; s2.arlock = '0; s2.arcache = '0; s2.arprot = '0; s2.arqos = '0;
        s2.rready  = '0;
        m2.arready = '0; m2.rid = '0; m2.rdata = '0; m2.rresp = '0; m2.rlast = 1'b0; m2.rvalid = '0;
        s3.arvalid = '0; s3.arid = '0; s3.araddr = '0; s3.arlen = '0; s3.arsize = '0;
        s3.arburst = '0; s3.arlock = '0; s3.arcache = '0; s3.arprot = '0; s3.arqos = '0;
        s3.rready  = '0;
        m3.arready = '0; m3.rid = '0; m3.rdata = '0; m3.rresp = '0; m3.rlast = 1'b0; m3.rvalid = '0;
        ar_exp.delete();
        r_exp.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_ar_drained(input string name);
        total_cnt++;
        if (ar_exp.size() != 0)
            $display("[TB] FAIL %s: %0d expected ARs never appeared, required 0", name, ar_exp.size());
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({m2.arvalid, m2.arid, m2.araddr, m2.arlen} !== '0)
            $display("[TB] FAIL reset_outputs: arvalid=%b arid=%h araddr=%h required all 0",
                     m2.arvalid, m2.arid, m2.araddr);
        else pass_cnt++;

        set_ar(0, 1'b1, 8'h11, 32'h0000_0100, 8'd0);
        set_ar(1, 1'b1, 8'h22, 32'h0000_0200, 8'd0);
        #1;
        total_cnt++;
        if (s2.arready !== 2'b01) $display("[TB] FAIL reset_pre_grant: arready=%b required 01", s2.arready);
        else pass_cnt++;
        cycle();
        total_cnt++;
        if (m2.arvalid !== 1'b1 || m2.arid !== 9'h011)
            $display("[TB] FAIL reset_held_ar: arvalid=%b arid=%h required 1/011", m2.arvalid, m2.arid);
        else pass_cnt++;

        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (m2.arvalid !== 1'b0 || s2.arready !== 2'b00)
            $display("[TB] FAIL reset_async: arvalid=%b arready=%b required 0/00", m2.arvalid, s2.arready);
        else pass_cnt++;
        ar_exp.delete();
        cycle();
        rst_n = 1'b1;
        m2.arready = 1'b1;
        #1;
        total_cnt++;
        if (s2.arready !== 2'b01)
            $display("[TB] FAIL reset_first_grant: arready=%b required 01", s2.arready);
        else pass_cnt++;
        push_ar(0, 8'h11, 32'h0000_0100, 8'd0);
        cycle();
        set_ar(0, 1'b0, 8'h00, 32'h0, 8'd0);
        set_ar(1, 1'b0, 8'h00, 32'h0, 8'd0);
        cycle();
        check_ar_drained("reset_drain");
    endtask

    task automatic test_round_robin();
        logic [7:0]  ids [2];
        logic [31:0] addrs [2];
        int w;
        ids[0] = 8'hA0; ids[1] = 8'hB1;
        addrs[0] = 32'h0000_1000; addrs[1] = 32'h0000_2000;
        do_reset();
        m2.arready = 1'b1;
        set_ar(0, 1'b1, ids[0], addrs[0], 8'd1);
        set_ar(1, 1'b1, ids[1], addrs[1], 8'd2);
        for (int k = 0; k < 4; k++) begin
            w = k % 2;
            #1;
            total_cnt++;
            if (s2.arready !== 2'(1 << w))
                $display("[TB] FAIL rr_grant%0d: arready=%b required %b", k, s2.arready, 2'(1 << w));
            else pass_cnt++;
            push_ar(w, ids[w], addrs[w], (w == 0) ? 8'd1 : 8'd2);
            cycle();
            total_cnt++;
            if (m2.arvalid !== 1'b1 || m2.arid[8] !== w[0])
                $display("[TB] FAIL rr_arid%0d: arvalid=%b arid_msb=%b required 1/%b", k, m2.arvalid, m2.arid[8], w[0]);
            else pass_cnt++;
        end
        set_ar(0, 1'b0, 8'h00, 32'h0, 8'd0);
        set_ar(1, 1'b0, 8'h00, 32'h0, 8'd0);
        cycle();
        cycle();
        check_ar_drained("rr_drain");
    endtask

    task automatic test_backpressure();
        do_reset();
        set_ar(0, 1'b1, 8'h33, 32'h0000_3000, 8'd0);
        #1;
        total_cnt++;
        if (s2.arready !== 2'b01) $display("[TB] FAIL bp_first: arready=%b required 01", s2.arready);
        else pass_cnt++;
        push_ar(0, 8'h33, 32'h0000_3000, 8'd0);
        cycle();
        set_ar(0, 1'b1, 8'h34, 32'h0000_3004, 8'd0);
        set_ar(1, 1'b1, 8'h44, 32'h0000_4000, 8'd5);
        for (int k = 0; k < 5; k++) begin
            #1;
            total_cnt++;
            if (m2.arvalid !== 1'b1 || m2.arid !== 9'h033 || m2.araddr !== 32'h0000_3000 || s2.arready !== 2'b00)
                $display("[TB] FAIL bp_stall%0d: arvalid=%b arid=%h araddr=%h arready=%b required 1/033/00003000/00",
                         k, m2.arvalid, m2.arid, m2.araddr, s2.arready);
            else pass_cnt++;
            cycle();
        end
        m2.arready = 1'b1;
        #1;
        total_cnt++;
        if (s2.arready !== 2'b10) $display("[TB] FAIL bp_release: arready=%b required 10", s2.arready);
        else pass_cnt++;
        push_ar(1, 8'h44, 32'h0000_4000, 8'd5);
        cycle();
        set_ar(1, 1'b0, 8'h00, 32'h0, 8'd0);
        #1;
        total_cnt++;
        if (s2.arready !== 2'b01) $display("[TB] FAIL bp_next: arready=%b required 01", s2.arready);
        else pass_cnt++;
        push_ar(0, 8'h34, 32'h0000_3004, 8'd0);
        cycle();
        set_ar(0, 1'b0, 8'h00, 32'h0, 8'd0);
        cycle();
        cycle();
        check_ar_drained("bp_drain");
    endtask

    task automatic test_throttle();
        do_reset();
        m2.arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_ar(0, 1'b1, 8'(8'h50 + k), 32'h0000_5000 + 32'(16 * k), 8'd0);
            #1;
            total_cnt++;
            if (s2.arready !== 2'b01) $display("[TB] FAIL thr_grant%0d: arready=%b required 01", k, s2.arready);
            else pass_cnt++;
            push_ar(0, 8'(8'h50 + k), 32'h0000_5000 + 32'(16 * k), 8'd0);
            cycle();
        end
        set_ar(0, 1'b1, 8'h54, 32'h0000_5040, 8'd0);
        #1;
        total_cnt++;
        if (s2.arready !== 2'b00 || dut2.cnt[0] !== 3'd4)
            $display("[TB] FAIL thr_blocked: arready=%b cnt0=%0d required 00/4", s2.arready, dut2.cnt[0]);
        else pass_cnt++;
        cycle();
        set_ar(1, 1'b1, 8'h60, 32'h0000_6000, 8'd0);
        #1;
        total_cnt++;
        if (s2.arready !== 2'b10) $display("[TB] FAIL thr_port1: arready=%b required 10", s2.arready);
        else pass_cnt++;
        push_ar(1, 8'h60, 32'h0000_6000, 8'd0);
        cycle();
        set_ar(1, 1'b0, 8'h00, 32'h0, 8'd0);
        m2.rvalid = 1'b1; m2.rid = 9'h050; m2.rlast = 1'b1; s2.rready = 2'b01;
        #1;
        total_cnt++;
        if (s2.arready !== 2'b00 || m2.rready !== 1'b1)
            $display("[TB] FAIL thr_rlast_cycle: arready=%b rready=%b required 00/1", s2.arready, m2.rready);
        else pass_cnt++;
        cycle();
        m2.rvalid = 1'b0; m2.rlast = 1'b0; s2.rready = 2'b00;
        #1;
        total_cnt++;
        if (s2.arready !== 2'b01 || dut2.cnt[0] !== 3'd3)
            $display("[TB] FAIL thr_reopen: arready=%b cnt0=%0d required 01/3", s2.arready, dut2.cnt[0]);
        else pass_cnt++;
        push_ar(0, 8'h54, 32'h0000_5040, 8'd0);
        cycle();
        set_ar(0, 1'b0, 8'h00, 32'h0, 8'd0);
        cycle();
        cycle();
        check_ar_drained("thr_drain");
    endtask

    task automatic test_r_routing();
        int   beat;
        int   cyc;
        logic rr_pat;
        r_t   e;
        do_reset();
        m2.arready = 1'b1;
        set_ar(1, 1'b1, 8'h5A, 32'h0000_7000, 8'd3);
        #1;
        total_cnt++;
        if (s2.arready !== 2'b10) $display("[TB] FAIL rt_ar: arready=%b required 10", s2.arready);
        else pass_cnt++;
        push_ar(1, 8'h5A, 32'h0000_7000, 8'd3);
        cycle();
        set_ar(1, 1'b0, 8'h00, 32'h0, 8'd0);
        cycle();
        for (int b = 0; b < 4; b++) begin
            e.data = 32'hD000_0000 + 32'(b);
            e.last = (b == 3);
            r_exp.push_back(e);
        end
        beat = 0;
        cyc  = 0;
        while (beat < 4 && cyc < 20) begin
            rr_pat      = cyc[0];
            m2.rvalid   = 1'b1;
            m2.rid      = 9'h15A;
            m2.rdata    = 32'hD000_0000 + 32'(beat);
            m2.rlast    = (beat == 3);
            s2.rready   = {rr_pat, 1'b0};
            #1;
            total_cnt++;
            if (s2.rvalid !== 2'b10 || s2.rid !== 8'h5A || m2.rready !== rr_pat)
                $display("[TB] FAIL rt_route%0d: rvalid=%b rid=%h m_rready=%b required 10/5a/%b",
                         cyc, s2.rvalid, s2.rid, m2.rready, rr_pat);
            else pass_cnt++;
            if (s2.rvalid[1] && s2.rready[1]) begin
                e = r_exp.pop_front();
                total_cnt++;
                if (s2.rdata !== e.data || s2.rlast !== e.last || dut2.cnt[1] !== 3'd1)
                    $display("[TB] FAIL rt_beat%0d: rdata=%h rlast=%b cnt1=%0d required %h/%b/1",
                             beat, s2.rdata, s2.rlast, dut2.cnt[1], e.data, e.last);
                else pass_cnt++;
                beat++;
            end
            cycle();
            cyc++;
        end
        m2.rvalid = 1'b0; m2.rlast = 1'b0; s2.rready = 2'b00;
        #1;
        total_cnt++;
        if (beat != 4 || dut2.cnt[1] !== 3'd0)
            $display("[TB] FAIL rt_done: beats=%0d cnt1=%0d required 4/0", beat, dut2.cnt[1]);
        else pass_cnt++;
        m2.rvalid = 1'b1; m2.rlast = 1'b1; s2.rready = 2'b10;
        cycle();
        m2.rvalid = 1'b0; m2.rlast = 1'b0; s2.rready = 2'b00;
        #1;
        total_cnt++;
        if (dut2.cnt[1] !== 3'd0) $display("[TB] FAIL rt_no_wrap: cnt1=%0d required 0", dut2.cnt[1]);
        else pass_cnt++;
        check_ar_drained("rt_drain");
    endtask

    task automatic test_simultaneous();
        do_reset();
        m2.arready = 1'b1;
        set_ar(0, 1'b1, 8'h70, 32'h0000_8000, 8'd0);
        #1;
        push_ar(0, 8'h70, 32'h0000_8000, 8'd0);
        cycle();
        set_ar(0, 1'b1, 8'h71, 32'h0000_8010, 8'd0);
        m2.rvalid = 1'b1; m2.rid = 9'h070; m2.rlast = 1'b1; s2.rready = 2'b01;
        #1;
        total_cnt++;
        if (s2.arready !== 2'b01) $display("[TB] FAIL sim_grant: arready=%b required 01", s2.arready);
        else pass_cnt++;
        push_ar(0, 8'h71, 32'h0000_8010, 8'd0);
        cycle();
        m2.rvalid = 1'b0; m2.rlast = 1'b0; s2.rready = 2'b00;
        set_ar(0, 1'b0, 8'h00, 32'h0, 8'd0);
        #1;
        total_cnt++;
        if (dut2.cnt[0] !== 3'd1) $display("[TB] FAIL sim_cnt: cnt0=%0d required 1", dut2.cnt[0]);
        else pass_cnt++;
        cycle();
        cycle();
        check_ar_drained("sim_drain");
    endtask

    task automatic test_three_port();
        int w;
        do_reset();
        m3.arready = 1'b1;
        s3.arid    = {8'h32, 8'h31, 8'h30};
        s3.arvalid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            w = k % 3;
            #1;
            total_cnt++;
            if (s3.arready !== 3'(1 << w))
                $display("[TB] FAIL p3_grant%0d: arready=%b required %b", k, s3.arready, 3'(1 << w));
            else pass_cnt++;
            cycle();
            total_cnt++;
            if (m3.arid !== {2'(w), 8'(8'h30 + w)})
                $display("[TB] FAIL p3_arid%0d: arid=%h required %h", k, m3.arid, {2'(w), 8'(8'h30 + w)});
            else pass_cnt++;
        end
        s3.arvalid = 3'b000;
        m3.rvalid = 1'b1; m3.rid = {2'd3, 8'h77}; m3.rlast = 1'b1; s3.rready = 3'b000;
        #1;
        total_cnt++;
        if (s3.rvalid !== 3'b000 || m3.rready !== 1'b1)
            $display("[TB] FAIL p3_drop: rvalid=%b rready=%b required 000/1", s3.rvalid, m3.rready);
        else pass_cnt++;
        m3.rlast = 1'b0;
        m3.rid   = {2'd2, 8'h77};
        #1;
        total_cnt++;
        if (s3.rvalid !== 3'b100 || m3.rready !== 1'b0)
            $display("[TB] FAIL p3_route2: rvalid=%b rready=%b required 100/0", s3.rvalid, m3.rready);
        else pass_cnt++;
        m3.rvalid = 1'b0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_throttle();
        test_r_routing();
        test_simultaneous();
        test_three_port();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
